cp_fifo_controller: RTL and testbench

//  Sequences the CP's graphics FIFO, a ring buffer in main memory bounded by FIFOBase/FIFOEnd.

---
 rtl/cp_pkg.sv | 17 +
 rtl/cp_ring_ptr.sv | 33 +++
 rtl/cp_fifo_controller.sv | 113 +++++++++++
 tb/tb_cp_fifo_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared command-processor types: block geometry, FIFO sequencer states, pointer alignment helper.
package cp_pkg;

  localparam int CP_BLOCK_BYTES = 32;
  localparam int CP_PTR_ALIGN   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BREAK = 2'd2
  } cp_fifo_state_t;

  function automatic logic [31:0] cp_align(input logic [31:0] a);
    return a & ~((32'd1 << CP_PTR_ALIGN) - 32'd1);
  endfunction

endpackage

// File: rtl/cp_ring_ptr.sv
// Block-aligned ring pointer: wraps to base once it reaches the end block; load forces base.
// Single-cycle update, no backpressure (advance/load are accepted every cycle).
module cp_ring_ptr
  import cp_pkg::*;
#(
  parameter int BLOCK_BYTES = CP_BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        advance,
  input  logic        load,
  input  logic [31:0] base,
  input  logic [31:0] fifo_end,
  output logic [31:0] ptr
);

  logic [31:0] ptr_inc;
  logic        at_end;

  assign ptr_inc = ptr + 32'(BLOCK_BYTES);
  assign at_end  = cp_align(ptr) >= cp_align(fifo_end);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= cp_align(base);
    end else if (advance) begin
      ptr <= at_end ? cp_align(base) : cp_align(ptr_inc);
    end
  end

endmodule

// File: rtl/cp_fifo_controller.sv
// CP graphics FIFO sequencer: tracks WP/RP/distance, fetches blocks, raises watermark/breakpoint events.
// Strobe-to-MemReq 2 cycles; fetch waits on ParserReady, MemReq is held until MemAck.
module cp_fifo_controller
  import cp_pkg::*;
#(
  parameter int BLOCK_BYTES = CP_BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] FIFOBase,
  input  logic [31:0] FIFOEnd,
  input  logic [31:0] FIFOHighWatermark,
  input  logic [31:0] FIFOLowWatermark,
  input  logic [31:0] FIFOBreakpoint,
  input  logic        EnGPFIFO,
  input  logic        EnGPLink,
  input  logic        EnBP,
  input  logic        EnFIFOOverflow,
  input  logic        EnFIFOUnderflow,
  input  logic        SyncPointers,
  input  logic        PIWriteStrobe,
  input  logic        ParserReady,
  input  logic        ParserIdle,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  output logic [31:0] FIFOWritePointer,
  output logic [31:0] FIFOReadPointer,
  output logic [31:0] FIFORWDistance,
  output logic        IntBP,
  output logic        IntFIFOverflow,
  output logic        IntFIFOUnderflow,
  output logic        StatGPReadIdle,
  output logic        StatGPIdle
);

  cp_fifo_state_t state, state_nxt;
  logic        sync_pend, bp_armed, hi_q, lo_q;
  logic        wr, rd_ack, sync_apply, wp_adv, rp_adv, bp_hit, fetch_ok;
  logic        dist_hi, dist_lo;
  logic [31:0] blk;

  assign blk      = 32'(BLOCK_BYTES);
  assign wr       = PIWriteStrobe & EnGPLink;
  assign rd_ack   = (state == REQ) & MemAck;
  // A sync seen mid-fetch is deferred to the ack so the bus cycle is never abandoned.
  assign sync_apply = (state == REQ) ? (MemAck & (sync_pend | SyncPointers)) : SyncPointers;
  assign wp_adv   = wr & ~sync_apply;
  assign rp_adv   = rd_ack & ~sync_apply;
  assign bp_hit   = EnBP & bp_armed & (FIFOReadPointer == cp_align(FIFOBreakpoint));
  assign fetch_ok = EnGPFIFO & (FIFORWDistance != '0) & ParserReady;
  assign dist_hi  = FIFORWDistance > FIFOHighWatermark;
  assign dist_lo  = FIFORWDistance < FIFOLowWatermark;

  cp_ring_ptr #(.BLOCK_BYTES(BLOCK_BYTES)) u_wp (
    .clk(clk), .resetn(resetn), .advance(wp_adv), .load(sync_apply),
    .base(FIFOBase), .fifo_end(FIFOEnd), .ptr(FIFOWritePointer)
  );

  cp_ring_ptr #(.BLOCK_BYTES(BLOCK_BYTES)) u_rp (
    .clk(clk), .resetn(resetn), .advance(rp_adv), .load(sync_apply),
    .base(FIFOBase), .fifo_end(FIFOEnd), .ptr(FIFOReadPointer)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (SyncPointers)  state_nxt = IDLE;
        else if (bp_hit)   state_nxt = BREAK;
        else if (fetch_ok) state_nxt = REQ;
      end
      REQ:     if (MemAck) state_nxt = IDLE;
      BREAK:   if (SyncPointers || !EnBP) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      sync_pend        <= 1'b0;
      bp_armed         <= 1'b1;
      FIFORWDistance   <= '0;
      hi_q             <= 1'b0;
      lo_q             <= 1'b0;
      IntBP            <= 1'b0;
      IntFIFOverflow   <= 1'b0;
      IntFIFOUnderflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_pend <= (state == REQ) & (sync_pend | SyncPointers) & ~MemAck;
      // Breakpoint re-arms only once the read pointer has moved off the halted block.
      if ((state == IDLE) && (state_nxt == BREAK)) bp_armed <= 1'b0;
      else if (rp_adv || sync_apply)               bp_armed <= 1'b1;
      if (sync_apply)
        FIFORWDistance <= '0;
      else
        FIFORWDistance <= FIFORWDistance + (wp_adv ? blk : 32'd0) - (rp_adv ? blk : 32'd0);
      hi_q             <= dist_hi;
      lo_q             <= dist_lo;
      IntBP            <= (state == IDLE) && (state_nxt == BREAK);
      IntFIFOverflow   <= EnFIFOOverflow & dist_hi & ~hi_q;
      IntFIFOUnderflow <= EnFIFOUnderflow & dist_lo & ~lo_q;
    end
  end

  assign MemReq         = (state == REQ);
  assign MemAddr        = FIFOReadPointer;
  assign StatGPReadIdle = (state != REQ) & ((FIFORWDistance == '0) | ~EnGPFIFO);
  assign StatGPIdle     = StatGPReadIdle & ParserIdle;

endmodule

// File: tb/tb_cp_fifo_controller.sv
// Self-checking bench for cp_fifo_controller: directed literal scenarios plus a randomized run
// compared every cycle against a behavioural model of the FIFO sequencer.
module tb_cp_fifo_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [31:0] FIFOBase, FIFOEnd, FIFOHighWatermark, FIFOLowWatermark, FIFOBreakpoint;
  logic        EnGPFIFO, EnGPLink, EnBP, EnFIFOOverflow, EnFIFOUnderflow;
  logic        SyncPointers, PIWriteStrobe, ParserReady, ParserIdle;
  logic        MemReq, MemAck;
  logic [31:0] MemAddr, FIFOWritePointer, FIFOReadPointer, FIFORWDistance;
  logic        IntBP, IntFIFOverflow, IntFIFOUnderflow, StatGPReadIdle, StatGPIdle;

  cp_fifo_controller dut (
    .clk(clk), .resetn(resetn),
    .FIFOBase(FIFOBase), .FIFOEnd(FIFOEnd),
    .FIFOHighWatermark(FIFOHighWatermark), .FIFOLowWatermark(FIFOLowWatermark),
    .FIFOBreakpoint(FIFOBreakpoint),
    .EnGPFIFO(EnGPFIFO), .EnGPLink(EnGPLink), .EnBP(EnBP),
    .EnFIFOOverflow(EnFIFOOverflow), .EnFIFOUnderflow(EnFIFOUnderflow),
    .SyncPointers(SyncPointers), .PIWriteStrobe(PIWriteStrobe),
    .ParserReady(ParserReady), .ParserIdle(ParserIdle),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .FIFOWritePointer(FIFOWritePointer), .FIFOReadPointer(FIFOReadPointer),
    .FIFORWDistance(FIFORWDistance),
    .IntBP(IntBP), .IntFIFOverflow(IntFIFOverflow), .IntFIFOUnderflow(IntFIFOUnderflow),
    .StatGPReadIdle(StatGPReadIdle), .StatGPIdle(StatGPIdle)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Memory responder: acks after ack_dly cycles of MemReq, logs fetched addresses
  logic        auto_en, auto_ack, man_ack;
  int          ack_dly, ack_cnt;
  logic [31:0] fetched[$];
  assign MemAck = auto_ack | man_ack;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      auto_ack = 1'b0;
      ack_cnt  = 0;
    end else if (auto_ack) begin
      auto_ack = 1'b0;
      ack_cnt  = 0;
    end else if (auto_en && MemReq) begin
      if (ack_cnt >= ack_dly) begin
        auto_ack = 1'b1;
        fetched.push_back(MemAddr);
      end else begin
        ack_cnt++;
      end
    end
  end

  // Behavioural model: ring positions, a fetch-outstanding flag and a halted flag
  logic [31:0] m_wp, m_rp, m_dist;
  logic        m_busy, m_halt, m_armed, m_spend, m_hi, m_lo;
  logic        e_bp, e_ovf, e_unf;
  logic        m_wr, m_sync, m_rd, m_hi_now, m_lo_now;

  function automatic logic [31:0] ring_next(input logic [31:0] p);
    if ((p >> 5) >= (FIFOEnd >> 5)) return FIFOBase & ~32'h1f;
    return (p & ~32'h1f) + 32'd32;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_wp = '0; m_rp = '0; m_dist = '0;
      m_busy = 1'b0; m_halt = 1'b0; m_armed = 1'b1; m_spend = 1'b0;
      m_hi = 1'b0; m_lo = 1'b0; e_bp = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    end else begin
      m_wr     = PIWriteStrobe && EnGPLink;
      m_hi_now = m_dist > FIFOHighWatermark;
      m_lo_now = m_dist < FIFOLowWatermark;
      e_ovf    = EnFIFOOverflow && m_hi_now && !m_hi;
      e_unf    = EnFIFOUnderflow && m_lo_now && !m_lo;
      m_hi     = m_hi_now;
      m_lo     = m_lo_now;
      e_bp = 1'b0; m_sync = 1'b0; m_rd = 1'b0;
      if (m_busy) begin
        if (MemAck) begin
          m_busy = 1'b0;
          if (m_spend || SyncPointers) m_sync = 1'b1;
          else m_rd = 1'b1;
          m_spend = 1'b0;
        end else if (SyncPointers) begin
          m_spend = 1'b1;
        end
      end else if (SyncPointers) begin
        m_sync = 1'b1;
        m_halt = 1'b0;
      end else if (m_halt) begin
        if (!EnBP) m_halt = 1'b0;
      end else if (EnBP && m_armed && m_rp == (FIFOBreakpoint & ~32'h1f)) begin
        m_halt = 1'b1; m_armed = 1'b0; e_bp = 1'b1;
      end else if (EnGPFIFO && m_dist != 0 && ParserReady) begin
        m_busy = 1'b1;
      end
      if (m_sync) begin
        m_wp = FIFOBase & ~32'h1f; m_rp = FIFOBase & ~32'h1f; m_dist = '0; m_armed = 1'b1;
      end else begin
        if (m_wr) begin m_wp = ring_next(m_wp); m_dist += 32'd32; end
        if (m_rd) begin m_rp = ring_next(m_rp); m_dist -= 32'd32; m_armed = 1'b1; end
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters for directed checks
  logic chk_on = 1'b0;
  int   bp_cnt = 0, ovf_cnt = 0, unf_cnt = 0;
  logic exp_ri;

  always @(negedge clk) begin
    if (IntBP === 1'b1) bp_cnt++;
    if (IntFIFOverflow === 1'b1) ovf_cnt++;
    if (IntFIFOUnderflow === 1'b1) unf_cnt++;
    if (chk_on) begin
      exp_ri = !m_busy && (m_dist == 0 || !EnGPFIFO);
      chk1 ("MemReq", MemReq, m_busy);
      chk32("MemAddr", MemAddr, m_rp);
      chk32("WritePointer", FIFOWritePointer, m_wp);
      chk32("ReadPointer", FIFOReadPointer, m_rp);
      chk32("RWDistance", FIFORWDistance, m_dist);
      chk1 ("IntBP", IntBP, e_bp);
      chk1 ("IntFIFOverflow", IntFIFOverflow, e_ovf);
      chk1 ("IntFIFOUnderflow", IntFIFOUnderflow, e_unf);
      chk1 ("StatGPReadIdle", StatGPReadIdle, exp_ri);
      chk1 ("StatGPIdle", StatGPIdle, exp_ri && ParserIdle);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic strobe();
    PIWriteStrobe = 1'b1; cyc(); PIWriteStrobe = 1'b0;
  endtask

  task automatic sync();
    SyncPointers = 1'b1; cyc(); SyncPointers = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (MemReq !== 1'b1 && k < 50) begin cyc(); k++; end
    chk1({name, " MemReq seen"}, MemReq, 1'b1);
  endtask

  logic [31:0] exp_wp[4];
  int f0, b0, o0, u0;
  int nblk;

  initial begin
    resetn = 1'b1;
    FIFOBase = 32'h1000; FIFOEnd = 32'h1060; FIFOBreakpoint = 32'h0;
    FIFOHighWatermark = 32'hFFFF_FFFF; FIFOLowWatermark = 32'h0;
    EnGPFIFO = 1'b0; EnGPLink = 1'b1; EnBP = 1'b0;
    EnFIFOOverflow = 1'b0; EnFIFOUnderflow = 1'b0;
    SyncPointers = 1'b0; PIWriteStrobe = 1'b0; ParserReady = 1'b1; ParserIdle = 1'b1;
    auto_en = 1'b1; man_ack = 1'b0; ack_dly = 3;
    #2 resetn = 1'b0;
    cyc(3);
    chk1 ("reset MemReq", MemReq, 1'b0);
    chk32("reset WP", FIFOWritePointer, 32'h0);
    chk32("reset RP", FIFOReadPointer, 32'h0);
    chk32("reset distance", FIFORWDistance, 32'h0);
    chk1 ("reset IntBP", IntBP, 1'b0);
    chk1 ("reset StatGPReadIdle", StatGPReadIdle, 1'b1);
    resetn = 1'b1;
    chk_on = 1'b1;
    cyc();

    // Write pointer wraps across a four-block ring
    sync();
    exp_wp[0] = 32'h1020; exp_wp[1] = 32'h1040; exp_wp[2] = 32'h1060; exp_wp[3] = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      strobe();
      chk32("wrap WP", FIFOWritePointer, exp_wp[i]);
    end
    chk32("wrap distance", FIFORWDistance, 32'h80);
    sync();
    chk32("sync WP", FIFOWritePointer, 32'h1000);
    chk32("sync distance", FIFORWDistance, 32'h0);

    // Two blocks fetched in order, 2-cycle strobe-to-request latency
    f0 = fetched.size();
    EnGPFIFO = 1'b1;
    PIWriteStrobe = 1'b1;
    cyc();
    chk1("latency cycle1 MemReq", MemReq, 1'b0);
    cyc();
    PIWriteStrobe = 1'b0;
    chk1("latency cycle2 MemReq", MemReq, 1'b1);
    cyc(40);
    chk32("fetch count", 32'(fetched.size() - f0), 32'd2);
    if (fetched.size() >= f0 + 2) begin
      chk32("fetch addr0", fetched[f0], 32'h1000);
      chk32("fetch addr1", fetched[f0+1], 32'h1020);
    end
    chk32("drain distance", FIFORWDistance, 32'h0);
    chk1 ("drain StatGPReadIdle", StatGPReadIdle, 1'b1);

    // Strobe and ack in the same cycle, then sync while a fetch is outstanding
    EnGPFIFO = 1'b0;
    sync();
    strobe(); strobe();
    auto_en = 1'b0;
    EnGPFIFO = 1'b1;
    wait_req("same-cycle");
    chk32("same-cycle MemAddr", MemAddr, 32'h1000);
    man_ack = 1'b1; PIWriteStrobe = 1'b1;
    cyc();
    man_ack = 1'b0; PIWriteStrobe = 1'b0;
    chk32("same-cycle distance", FIFORWDistance, 32'h40);
    chk32("same-cycle WP", FIFOWritePointer, 32'h1060);
    chk32("same-cycle RP", FIFOReadPointer, 32'h1020);
    wait_req("sync-in-req");
    sync();
    chk1 ("sync-in-req held MemReq", MemReq, 1'b1);
    chk32("sync-in-req WP deferred", FIFOWritePointer, 32'h1060);
    man_ack = 1'b1; PIWriteStrobe = 1'b1;
    cyc();
    man_ack = 1'b0; PIWriteStrobe = 1'b0;
    chk32("sync-at-ack WP", FIFOWritePointer, 32'h1000);
    chk32("sync-at-ack RP", FIFOReadPointer, 32'h1000);
    chk32("sync-at-ack distance", FIFORWDistance, 32'h0);
    auto_en = 1'b1;

    // Watermark edges
    EnGPFIFO = 1'b0;
    FIFOHighWatermark = 32'h40;
    cyc(3);
    EnFIFOOverflow = 1'b1;
    o0 = ovf_cnt;
    strobe(); strobe(); strobe();
    cyc(3);
    chk32("overflow pulses", 32'(ovf_cnt - o0), 32'd1);
    chk32("overflow distance", FIFORWDistance, 32'h60);
    FIFOLowWatermark = 32'h20;
    cyc(3);
    EnFIFOUnderflow = 1'b1;
    u0 = unf_cnt;
    EnGPFIFO = 1'b1;
    cyc(60);
    chk32("underflow pulses", 32'(unf_cnt - u0), 32'd1);
    chk32("overflow pulses after drain", 32'(ovf_cnt - o0), 32'd1);
    EnFIFOOverflow = 1'b0; EnFIFOUnderflow = 1'b0;
    FIFOHighWatermark = 32'hFFFF_FFFF; FIFOLowWatermark = 32'h0;

    // Breakpoint halts before the block at FIFOBreakpoint
    EnGPFIFO = 1'b0;
    sync();
    strobe(); strobe(); strobe();
    FIFOBreakpoint = 32'h1020;
    EnBP = 1'b1;
    f0 = fetched.size(); b0 = bp_cnt;
    EnGPFIFO = 1'b1;
    cyc(40);
    chk32("bp fetch count", 32'(fetched.size() - f0), 32'd1);
    if (fetched.size() >= f0 + 1) chk32("bp fetch addr0", fetched[f0], 32'h1000);
    chk32("bp pulses", 32'(bp_cnt - b0), 32'd1);
    chk1 ("bp halted MemReq", MemReq, 1'b0);
    chk32("bp halted RP", FIFOReadPointer, 32'h1020);
    EnBP = 1'b0;
    cyc(40);
    chk32("bp resume count", 32'(fetched.size() - f0), 32'd3);
    if (fetched.size() >= f0 + 3) begin
      chk32("bp resume addr1", fetched[f0+1], 32'h1020);
      chk32("bp resume addr2", fetched[f0+2], 32'h1040);
    end
    chk32("bp resume distance", FIFORWDistance, 32'h0);

    // Randomized run against the model
    for (int seg = 0; seg < 8; seg++) begin
      nblk = int'($urandom_range(0, 5));
      FIFOBase = 32'($urandom_range(1, 2000)) << 5;
      FIFOEnd  = FIFOBase + 32'(nblk * 32) + 32'($urandom_range(0, 31));
      sync();
      for (int c = 0; c < 400; c++) begin
        PIWriteStrobe = ($urandom_range(0, 2) == 0);
        EnGPLink      = ($urandom_range(0, 9) != 0);
        EnGPFIFO      = ($urandom_range(0, 7) != 0);
        ParserReady   = ($urandom_range(0, 3) != 0);
        ParserIdle    = ($urandom_range(0, 1) == 1);
        SyncPointers  = ($urandom_range(0, 60) == 0);
        if ($urandom_range(0, 40) == 0) EnBP = ~EnBP;
        if ($urandom_range(0, 50) == 0)
          FIFOBreakpoint = FIFOBase + 32'($urandom_range(0, nblk) * 32) + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 30) == 0) EnFIFOOverflow = ~EnFIFOOverflow;
        if ($urandom_range(0, 30) == 0) EnFIFOUnderflow = ~EnFIFOUnderflow;
        if ($urandom_range(0, 40) == 0) FIFOHighWatermark = 32'($urandom_range(0, 8) * 32);
        if ($urandom_range(0, 40) == 0) FIFOLowWatermark = 32'($urandom_range(0, 4) * 32);
        if ($urandom_range(0, 20) == 0) ack_dly = int'($urandom_range(0, 3));
        cyc();
      end
    end
    PIWriteStrobe = 1'b0; SyncPointers = 1'b0; EnBP = 1'b0; EnGPLink = 1'b1;
    EnFIFOOverflow = 1'b0; EnFIFOUnderflow = 1'b0; ParserReady = 1'b1; ParserIdle = 1'b1;
    cyc(40);

    // Asynchronous reset while a fetch is outstanding
    EnGPFIFO = 1'b0;
    FIFOBase = 32'h1000; FIFOEnd = 32'h1060;
    sync();
    strobe();
    auto_en = 1'b0;
    EnGPFIFO = 1'b1;
    wait_req("reset-mid-req");
    resetn = 1'b0;
    #1;
    chk1 ("reset-mid-req MemReq", MemReq, 1'b0);
    chk32("reset-mid-req RP", FIFOReadPointer, 32'h0);
    chk32("reset-mid-req distance", FIFORWDistance, 32'h0);
    cyc(2);
    resetn = 1'b1;
    auto_en = 1'b1;
    cyc(5);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
